uop_load: RTL and testbench
===========================

# uop_load

Loads GEMM micro-op programs into the micro-op memory that `gemm` reads through `upc`. It is the write side of that memory.
- Accepts one 128-bit LOAD instruction.
- Issues a single burst read to the DRAM read port.
- Writes each returned 32-bit uop word into consecutive micro-op memory entries.
- Pulses `done` when finished.

It sits between the instruction dispatcher and the single-port uop memory.

## Interface
- `UOP_WIDTH`, 32, micro-op word width
- `UPC_WIDTH`, 13, micro-op memory address width
- `INS_WIDTH`, 128, instruction width
- `DRAM_ADDR_WIDTH`, 32, DRAM word address width
- `LEN_WIDTH`, 16, burst length width
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-low reset.
- `insn_valid` in 1, `insn_ready` out 1, `insn` in `INS_WIDTH`: instruction handshake.
- `rd_req_valid` out 1, `rd_req_ready` in 1, `rd_req_addr` out `DRAM_ADDR_WIDTH`, `rd_req_len` out `LEN_WIDTH`: burst read request.
- `rd_data_valid` in 1, `rd_data_ready` out 1, `rd_data` in `UOP_WIDTH`: read data beats.
- `uop_wr_we` out 1, `uop_wr_addr` out `UPC_WIDTH`, `uop_wr_data` out `UOP_WIDTH`: uop memory write port.
- `done` out 1: one-cycle completion pulse.
- `skipped` out 1: valid with `done`; set when the instruction was not a uop load.

## Operation
- Decoded fields: `opcode[2:0]` (LOAD=0), `memory_type[9:7]` (UOP=0), `sram_base[25:10]` (low `UPC_WIDTH` bits used), `dram_base[57:26]`, `x_size[73:58]`. All other bits are ignored.
- FSM states: IDLE, REQ, DATA, DONE.
- IDLE:
  - `insn_ready`=1.
  - On handshake, latch the fields and clear the beat counter.
  - If opcode≠LOAD or memory_type≠UOP, go to DONE with `skipped`=1.
  - Else if x_size=0, go to DONE with `skipped`=0.
  - Else go to REQ.
- REQ: `rd_req_valid`=1, `rd_req_addr`=dram_base, `rd_req_len`=x_size. Values are held stable until `rd_req_ready`; then go to DATA.
- DATA:
  - `rd_data_ready`=1.
  - Each accepted beat i (0-based) produces a registered write on the next cycle: `uop_wr_we`=1, addr=(sram_base+i) mod 2^UPC_WIDTH, data=beat.
  - On acceptance of beat x_size-1, go to DONE.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- Address arithmetic: sram_base+i is computed in `UPC_WIDTH` bits and wraps silently. dram_base is passed through unmodified.
- Beats arriving outside DATA are not accepted (`rd_data_ready`=0).
- No back-pressure from uop memory; writes always complete in one cycle.

## Timing
- Reset values (asynchronous assert, synchronous release):
  - State=IDLE.
  - All outputs 0 except `insn_ready`=1.
  - Counters, latched fields and `skipped` are 0.
- Reset during REQ or DATA abandons the transfer with no `done`. Data still in flight from DRAM is the system's responsibility to flush.
- Insn handshake at cycle T: `rd_req_valid` rises at T+1.
- Beat accepted at cycle B: write appears at B+1.
- Last beat accepted at L: the last write and `done` both occur at L+1; `insn_ready` returns at L+2.
- Skip/zero-length path: handshake at T, `done` at T+1, `insn_ready` at T+2.
- Minimum total for N beats with zero-wait DRAM: handshake T, request T+1, beats T+2..T+N+1, `done` T+N+2.
- `insn_ready` is 0 from the cycle after handshake until the cycle after DONE. An instruction presented meanwhile is held by the sender.

## Structure
- Shared package `vta_pkg`:
  - opcode constants (LOAD, STORE, GEMM, FINISH, ALU);
  - memory_type constants (UOP, WGT, INP, ACC, OUT);
  - LOAD field bit offsets and widths;
  - the FSM state typedef.
- No sub-module: FSM, counter and write register fit in one module. The uop memory (`bram_sp`) is instantiated outside.

## Test plan
- LOAD, UOP, sram_base=0, dram_base=0x100, x_size=4, zero-wait DRAM returning 0xA0..0xA3:
  - request addr=0x100, len=4;
  - writes addr 0..3 with data 0xA0..0xA3 on consecutive cycles;
  - `done`=1, `skipped`=0 exactly once, 6 cycles after handshake.
- sram_base=0x1FFE, x_size=4 → writes to 0x1FFE, 0x1FFF, 0x0000, 0x0001.
- `rd_req_ready` held low 5 cycles and `rd_data_valid` toggled 1/0 → request fields stable throughout; exactly x_size writes in order; no write on idle cycles.
- memory_type=INP and separately opcode=GEMM → no request and no writes; `done`=1 with `skipped`=1 one cycle after handshake.
- x_size=0 → no request; `done`=1, `skipped`=0 at T+1.
- `rst` asserted mid-DATA after 2 of 8 beats → all outputs reset immediately and no `done`. A subsequent x_size=2 load completes normally at its own sram_base.

Source files
------------

// File: rtl/vta_pkg.sv
// Shared VTA definitions: widths, opcode and memory-type encodings, LOAD field
// layout and the uop loader state type.
package vta_pkg;

    localparam int UOP_WIDTH       = 32;
    localparam int UPC_WIDTH       = 13;
    localparam int INS_WIDTH       = 128;
    localparam int DRAM_ADDR_WIDTH = 32;
    localparam int LEN_WIDTH       = 16;

    localparam logic [2:0] OP_LOAD   = 3'd0;
    localparam logic [2:0] OP_STORE  = 3'd1;
    localparam logic [2:0] OP_GEMM   = 3'd2;
    localparam logic [2:0] OP_FINISH = 3'd3;
    localparam logic [2:0] OP_ALU    = 3'd4;

    localparam logic [2:0] MEM_UOP = 3'd0;
    localparam logic [2:0] MEM_WGT = 3'd1;
    localparam logic [2:0] MEM_INP = 3'd2;
    localparam logic [2:0] MEM_ACC = 3'd3;
    localparam logic [2:0] MEM_OUT = 3'd4;

    localparam int OPCODE_LSB    = 0;
    localparam int OPCODE_W      = 3;
    localparam int MEMTYPE_LSB   = 7;
    localparam int MEMTYPE_W     = 3;
    localparam int SRAM_BASE_LSB = 10;
    localparam int SRAM_BASE_W   = 16;
    localparam int DRAM_BASE_LSB = 26;
    localparam int DRAM_BASE_W   = 32;
    localparam int XSIZE_LSB     = 58;
    localparam int XSIZE_W       = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } uop_load_state_e;

    function automatic logic is_uop_load(input logic [INS_WIDTH-1:0] insn);
        return (insn[OPCODE_LSB +: OPCODE_W] == OP_LOAD) &&
               (insn[MEMTYPE_LSB +: MEMTYPE_W] == MEM_UOP);
    endfunction

endpackage

// File: rtl/uop_load_if.sv
// Bundle of the uop loader's instruction, DRAM read, uop-memory write and
// completion signals; master is the loader, slave is its environment.
interface uop_load_if;
    import vta_pkg::*;

    logic                       insn_valid;
    logic                       insn_ready;
    logic [INS_WIDTH-1:0]       insn;
    logic                       rd_req_valid;
    logic                       rd_req_ready;
    logic [DRAM_ADDR_WIDTH-1:0] rd_req_addr;
    logic [LEN_WIDTH-1:0]       rd_req_len;
    logic                       rd_data_valid;
    logic                       rd_data_ready;
    logic [UOP_WIDTH-1:0]       rd_data;
    logic                       uop_wr_we;
    logic [UPC_WIDTH-1:0]       uop_wr_addr;
    logic [UOP_WIDTH-1:0]       uop_wr_data;
    logic                       done;
    logic                       skipped;

    modport master (
        input  insn_valid, insn, rd_req_ready, rd_data_valid, rd_data,
        output insn_ready, rd_req_valid, rd_req_addr, rd_req_len, rd_data_ready,
               uop_wr_we, uop_wr_addr, uop_wr_data, done, skipped
    );

    modport slave (
        output insn_valid, insn, rd_req_ready, rd_data_valid, rd_data,
        input  insn_ready, rd_req_valid, rd_req_addr, rd_req_len, rd_data_ready,
               uop_wr_we, uop_wr_addr, uop_wr_data, done, skipped
    );

endinterface

// File: rtl/uop_load.sv
// Micro-op loader: takes one LOAD instruction, issues one DRAM burst read and
// streams the returned words into consecutive uop memory entries.
module uop_load
    import vta_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    uop_load_if.master bus
);

    uop_load_state_e            state_r;
    uop_load_state_e            state_s;
    logic [UPC_WIDTH-1:0]       sram_base_r;
    logic [DRAM_ADDR_WIDTH-1:0] dram_base_r;
    logic [LEN_WIDTH-1:0]       x_size_r;
    logic [LEN_WIDTH-1:0]       cnt_r;
    logic                       skipped_r;
    logic                       insn_ready_r;
    logic                       rd_req_valid_r;
    logic                       rd_data_ready_r;
    logic                       done_r;
    logic                       wr_we_r;
    logic [UPC_WIDTH-1:0]       wr_addr_r;
    logic [UOP_WIDTH-1:0]       wr_data_r;

    logic                       insn_fire_s;
    logic                       req_fire_s;
    logic                       beat_fire_s;
    logic                       load_ok_s;
    logic [LEN_WIDTH-1:0]       insn_xsize_s;

    assign insn_fire_s  = insn_ready_r & bus.insn_valid;
    assign req_fire_s   = rd_req_valid_r & bus.rd_req_ready;
    assign beat_fire_s  = rd_data_ready_r & bus.rd_data_valid;
    assign load_ok_s    = is_uop_load(bus.insn);
    assign insn_xsize_s = bus.insn[XSIZE_LSB +: XSIZE_W];

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (insn_fire_s) begin
                    if (!load_ok_s || (insn_xsize_s == 16'd0)) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_REQ;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (req_fire_s) begin
                    state_s = ST_DATA;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_DATA: begin
                if (beat_fire_s && (cnt_r == (x_size_r - 16'd1))) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Handshake and completion outputs registered from the next state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            insn_ready_r    <= 1'b1;
            rd_req_valid_r  <= 1'b0;
            rd_data_ready_r <= 1'b0;
            done_r          <= 1'b0;
        end else begin
            insn_ready_r    <= (state_s == ST_IDLE);
            rd_req_valid_r  <= (state_s == ST_REQ);
            rd_data_ready_r <= (state_s == ST_DATA);
            done_r          <= (state_s == ST_DONE);
        end
    end

    // Latched instruction fields and beat counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sram_base_r <= '0;
            dram_base_r <= '0;
            x_size_r    <= '0;
            cnt_r       <= '0;
            skipped_r   <= 1'b0;
        end else if (insn_fire_s) begin
            sram_base_r <= bus.insn[SRAM_BASE_LSB +: UPC_WIDTH];
            dram_base_r <= bus.insn[DRAM_BASE_LSB +: DRAM_BASE_W];
            x_size_r    <= insn_xsize_s;
            cnt_r       <= '0;
            skipped_r   <= !load_ok_s;
        end else if (beat_fire_s) begin
            cnt_r <= cnt_r + 16'd1;
        end
    end

    // Uop memory write register; address wraps within the uop memory
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_we_r   <= 1'b0;
            wr_addr_r <= '0;
            wr_data_r <= '0;
        end else begin
            wr_we_r <= beat_fire_s;
            if (beat_fire_s) begin
                wr_addr_r <= sram_base_r + cnt_r[UPC_WIDTH-1:0];
                wr_data_r <= bus.rd_data;
            end
        end
    end

    assign bus.insn_ready    = insn_ready_r;
    assign bus.rd_req_valid  = rd_req_valid_r;
    assign bus.rd_req_addr   = dram_base_r;
    assign bus.rd_req_len    = x_size_r;
    assign bus.rd_data_ready = rd_data_ready_r;
    assign bus.uop_wr_we     = wr_we_r;
    assign bus.uop_wr_addr   = wr_addr_r;
    assign bus.uop_wr_data   = wr_data_r;
    assign bus.done          = done_r;
    assign bus.skipped       = skipped_r;

endmodule

// File: tb/tb_uop_load.sv
// Directed, table-driven bench for uop_load with a cycle-stepped DRAM model
// and hand-written reset-abort sequence.
module tb_uop_load;
    import vta_pkg::*;

    typedef struct {
        logic [2:0]  opc;
        logic [2:0]  mtype;
        logic [15:0] sram;
        logic [31:0] dram;
        logic [15:0] xs;
        int          req_wait;
        bit          gap;
        logic [31:0] dbase;
        bit          exp_skip;
        bit          exp_req;
        int          exp_done;
    } vec_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    vec_t vecs[7];

    uop_load_if bus();

    uop_load dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] mk_insn(input logic [2:0] opc, input logic [2:0] mt,
                                             input logic [15:0] sram, input logic [31:0] dram,
                                             input logic [15:0] xs);
        logic [127:0] w;
        w          = '0;
        w[127:74]  = {2'b10, 52'hA5A5A5A5A5A5A};
        w[6:3]     = 4'b1011;
        w[2:0]     = opc;
        w[9:7]     = mt;
        w[25:10]   = sram;
        w[57:26]   = dram;
        w[73:58]   = xs;
        return w;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int          req_cyc, bi, wi, done_cnt, done_k, exp_wr, ak;
        int          acc_q[$];
        bit          req_acc, ph, offer, beat_acc, req_now;
        logic [12:0] ea;
        req_cyc = 0; bi = 0; wi = 0; done_cnt = 0; done_k = -10;
        req_acc = 1'b0; ph = 1'b0;
        exp_wr = v.exp_req ? int'(v.xs) : 0;
        @(negedge clk);
        chk({tag, " idle_ready"}, bus.insn_ready, 1'b1);
        bus.insn       = mk_insn(v.opc, v.mtype, v.sram, v.dram, v.xs);
        bus.insn_valid = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (k == 1) bus.insn_valid = 1'b0;
            if (done_cnt > 0 && k == done_k + 1) begin
                chk({tag, " ready_after_done"}, bus.insn_ready, 1'b1);
                break;
            end
            chk({tag, " busy_not_ready"}, bus.insn_ready, 1'b0);
            if (bus.rd_req_valid) begin
                req_cyc++;
                chk({tag, " req_expected"}, bus.rd_req_valid, v.exp_req);
                chk({tag, " req_addr"}, bus.rd_req_addr, v.dram);
                chk({tag, " req_len"}, bus.rd_req_len, v.xs);
            end
            if (bus.uop_wr_we) begin
                ea = v.sram[12:0] + wi[12:0];
                chk({tag, " wr_addr"}, bus.uop_wr_addr, ea);
                chk({tag, " wr_data"}, bus.uop_wr_data, v.dbase + wi);
                if (acc_q.size() > 0) begin
                    ak = acc_q.pop_front();
                    chk({tag, " wr_cycle"}, k, ak + 1);
                end else begin
                    chk({tag, " wr_without_beat"}, bus.uop_wr_we, 1'b0);
                end
                wi++;
            end
            if (bus.done) begin
                done_cnt++;
                done_k = k;
                chk({tag, " skipped"}, bus.skipped, v.exp_skip);
            end
            bus.rd_req_ready  = bus.rd_req_valid && (req_cyc > v.req_wait);
            offer             = req_acc && (bi < int'(v.xs)) && (!v.gap || ph);
            bus.rd_data_valid = offer;
            bus.rd_data       = v.dbase + bi;
            beat_acc          = offer && bus.rd_data_ready;
            req_now           = bus.rd_req_valid && bus.rd_req_ready;
            if (req_acc) ph = !ph;
            if (beat_acc) begin
                acc_q.push_back(k);
                bi++;
            end
            if (req_now) begin
                req_acc = 1'b1;
                ph      = 1'b1;
            end
        end
        bus.rd_req_ready  = 1'b0;
        bus.rd_data_valid = 1'b0;
        chk({tag, " done_count"}, done_cnt, 1);
        chk({tag, " done_cycle"}, done_k, v.exp_done);
        chk({tag, " write_count"}, wi, exp_wr);
        chk({tag, " req_seen"}, req_cyc > 0, v.exp_req);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " insn_ready"}, bus.insn_ready, 1'b1);
        chk({tag, " rd_req_valid"}, bus.rd_req_valid, 1'b0);
        chk({tag, " rd_data_ready"}, bus.rd_data_ready, 1'b0);
        chk({tag, " uop_wr_we"}, bus.uop_wr_we, 1'b0);
        chk({tag, " done"}, bus.done, 1'b0);
        chk({tag, " skipped"}, bus.skipped, 1'b0);
        chk({tag, " rd_req_addr"}, bus.rd_req_addr, 32'd0);
        chk({tag, " rd_req_len"}, bus.rd_req_len, 16'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        //        opc       mtype    sram      dram          xs     wait gap dbase         skip req done
        vecs[0] = '{OP_LOAD, MEM_UOP, 16'h0000, 32'h00000100, 16'd4, 0,   0, 32'h000000A0, 0,   1,  6};
        vecs[1] = '{OP_LOAD, MEM_UOP, 16'h1FFE, 32'h00002000, 16'd4, 0,   0, 32'h000000B0, 0,   1,  6};
        vecs[2] = '{OP_LOAD, MEM_UOP, 16'h0123, 32'hDEADBEEF, 16'd4, 5,   1, 32'h000000C0, 0,   1,  14};
        vecs[3] = '{OP_LOAD, MEM_INP, 16'h0010, 32'h00000200, 16'd4, 0,   0, 32'h00000000, 1,   0,  1};
        vecs[4] = '{OP_GEMM, MEM_UOP, 16'h0010, 32'h00000200, 16'd4, 0,   0, 32'h00000000, 1,   0,  1};
        vecs[5] = '{OP_LOAD, MEM_UOP, 16'h0010, 32'h00000200, 16'd0, 0,   0, 32'h00000000, 0,   0,  1};
        vecs[6] = '{OP_LOAD, MEM_UOP, 16'hE005, 32'h12345678, 16'd1, 0,   0, 32'h55AA0001, 0,   1,  3};

        rst               = 1'b0;
        bus.insn_valid    = 1'b0;
        bus.insn          = '0;
        bus.rd_req_ready  = 1'b0;
        bus.rd_data_valid = 1'b0;
        bus.rd_data       = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset in the middle of an 8-beat transfer, after two beats
        @(negedge clk);
        bus.insn       = mk_insn(OP_LOAD, MEM_UOP, 16'h0040, 32'h00000300, 16'd8);
        bus.insn_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.insn_valid = 1'b0;
        chk("abort req_valid", bus.rd_req_valid, 1'b1);
        bus.rd_req_ready = 1'b1;
        @(negedge clk);
        bus.rd_req_ready  = 1'b0;
        bus.rd_data_valid = 1'b1;
        bus.rd_data       = 32'h000000D0;
        @(negedge clk);
        chk("abort wr0_addr", bus.uop_wr_addr, 13'h0040);
        chk("abort wr0_data", bus.uop_wr_data, 32'h000000D0);
        bus.rd_data = 32'h000000D1;
        @(negedge clk);
        chk("abort wr1_we", bus.uop_wr_we, 1'b1);
        chk("abort wr1_addr", bus.uop_wr_addr, 13'h0041);
        bus.rd_data_valid = 1'b0;
        rst               = 1'b0;
        #1;
        chk("abort immediate insn_ready", bus.insn_ready, 1'b1);
        chk("abort immediate rd_data_ready", bus.rd_data_ready, 1'b0);
        chk("abort immediate uop_wr_we", bus.uop_wr_we, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("abort held done", bus.done, 1'b0);
            chk("abort held we", bus.uop_wr_we, 1'b0);
        end
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("abort post done", bus.done, 1'b0);
        end
        run_vec('{OP_LOAD, MEM_UOP, 16'h0777, 32'h00000400, 16'd2, 0, 0, 32'h0000E000, 0, 1, 4},
                "after_abort");

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
